stopwatch_ctrl: RTL

Controller that sequences a cascade of wrap-around counters to form a mm:ss.cc stopwatch. A state machine responds to start/stop, lap and clear requests. A prescaler derives the 1/100 s tick from clk. Enables and carries are chained through centisecond, second and minute stages. A lap-freeze register holds the displayed value while counting continues underneath. It sits between the debounced button logic and the display driver.

---
 rtl/stopwatch_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss.cc stopwatch sequencer.
// Edge-detects the debounced button levels, runs an IDLE/RUN/PAUSED state machine,
// prescales clk down to a centisecond tick and cascades cs -> sec -> min counters.
// A lap snapshot can freeze the display while the live counters keep running.
module stopwatch_ctrl #(
  parameter int PRESCALE = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [6:0] cs_out,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             ss_q_r, lap_q_r, clr_q_r;
  logic             clr_req_s, ss_req_s, lap_req_s;
  logic [PRE_W-1:0] pre_r, pre_nxt_s;
  logic [6:0]       cs_r, cs_nxt_s, snap_cs_r, snap_cs_nxt_s, disp_cs_s;
  logic [5:0]       sec_r, sec_nxt_s, snap_sec_r, snap_sec_nxt_s, disp_sec_s;
  logic [5:0]       min_r, min_nxt_s, snap_min_r, snap_min_nxt_s, disp_min_s;
  logic             lap_act_r, lap_act_nxt_s;
  logic             count_en_s, tick_s, roll_nxt_s;
  logic             running_r, rollover_r;

  assign lap_active = lap_act_r;
  assign running    = running_r;
  assign rollover   = rollover_r;

  // Rising-edge requests with fixed priority clear > start_stop > lap.
  always_comb begin
    clr_req_s = clear & ~clr_q_r;
    ss_req_s  = start_stop & ~ss_q_r & ~clr_req_s;
    lap_req_s = lap & ~lap_q_r & ~clr_req_s & ~ss_req_s;
  end

  // Next-state logic of the IDLE/RUN/PAUSED controller.
  always_comb begin
    state_nxt_s = state_r;
    if (clr_req_s) begin
      state_nxt_s = ST_IDLE;
    end else if (ss_req_s) begin
      case (state_r)
        ST_IDLE:   state_nxt_s = ST_RUN;
        ST_RUN:    state_nxt_s = ST_PAUSED;
        ST_PAUSED: state_nxt_s = ST_RUN;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Prescaler, counter cascade, lap snapshot and display selection.
  always_comb begin
    // The prescaler only advances on cycles that start and stay in RUN, so the
    // entering and leaving edges do not consume part of a tick.
    count_en_s     = (state_r == ST_RUN) && (state_nxt_s == ST_RUN);
    pre_nxt_s      = pre_r;
    tick_s         = 1'b0;
    cs_nxt_s       = cs_r;
    sec_nxt_s      = sec_r;
    min_nxt_s      = min_r;
    roll_nxt_s     = 1'b0;
    lap_act_nxt_s  = lap_act_r;
    snap_cs_nxt_s  = snap_cs_r;
    snap_sec_nxt_s = snap_sec_r;
    snap_min_nxt_s = snap_min_r;
    if (clr_req_s) begin
      pre_nxt_s      = '0;
      cs_nxt_s       = 7'd0;
      sec_nxt_s      = 6'd0;
      min_nxt_s      = 6'd0;
      lap_act_nxt_s  = 1'b0;
      snap_cs_nxt_s  = 7'd0;
      snap_sec_nxt_s = 6'd0;
      snap_min_nxt_s = 6'd0;
    end else begin
      if (count_en_s) begin
        if (pre_r == PRE_LAST) begin
          pre_nxt_s = '0;
          tick_s    = 1'b1;
        end else begin
          pre_nxt_s = pre_r + PRE_W'(1);
        end
      end else begin
        pre_nxt_s = pre_r;
      end
      // All stages update on the tick edge itself; carries are combinational.
      if (tick_s) begin
        if (cs_r == 7'd99) begin
          cs_nxt_s = 7'd0;
          if (sec_r == 6'd59) begin
            sec_nxt_s = 6'd0;
            if (min_r == 6'd59) begin
              min_nxt_s  = 6'd0;
              roll_nxt_s = 1'b1;
            end else begin
              min_nxt_s = min_r + 6'd1;
            end
          end else begin
            sec_nxt_s = sec_r + 6'd1;
          end
        end else begin
          cs_nxt_s = cs_r + 7'd1;
        end
      end else begin
        cs_nxt_s = cs_r;
      end
      // Lap toggles in RUN (snapshot takes the pre-increment counts); in PAUSED
      // it can only release the freeze; in IDLE it does nothing.
      if (lap_req_s && (state_r == ST_RUN)) begin
        lap_act_nxt_s = ~lap_act_r;
        if (!lap_act_r) begin
          snap_cs_nxt_s  = cs_r;
          snap_sec_nxt_s = sec_r;
          snap_min_nxt_s = min_r;
        end else begin
          snap_cs_nxt_s = snap_cs_r;
        end
      end else if (lap_req_s && (state_r == ST_PAUSED)) begin
        lap_act_nxt_s = 1'b0;
      end else begin
        lap_act_nxt_s = lap_act_r;
      end
    end
    if (lap_act_nxt_s) begin
      disp_cs_s  = snap_cs_nxt_s;
      disp_sec_s = snap_sec_nxt_s;
      disp_min_s = snap_min_nxt_s;
    end else begin
      disp_cs_s  = cs_nxt_s;
      disp_sec_s = sec_nxt_s;
      disp_min_s = min_nxt_s;
    end
  end

  // State, counters, snapshot, edge-detect history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ss_q_r     <= 1'b0;
      lap_q_r    <= 1'b0;
      clr_q_r    <= 1'b0;
      pre_r      <= '0;
      cs_r       <= 7'd0;
      sec_r      <= 6'd0;
      min_r      <= 6'd0;
      snap_cs_r  <= 7'd0;
      snap_sec_r <= 6'd0;
      snap_min_r <= 6'd0;
      lap_act_r  <= 1'b0;
      running_r  <= 1'b0;
      rollover_r <= 1'b0;
      cs_out     <= 7'd0;
      sec_out    <= 6'd0;
      min_out    <= 6'd0;
    end else begin
      state_r    <= state_nxt_s;
      ss_q_r     <= start_stop;
      lap_q_r    <= lap;
      clr_q_r    <= clear;
      pre_r      <= pre_nxt_s;
      cs_r       <= cs_nxt_s;
      sec_r      <= sec_nxt_s;
      min_r      <= min_nxt_s;
      snap_cs_r  <= snap_cs_nxt_s;
      snap_sec_r <= snap_sec_nxt_s;
      snap_min_r <= snap_min_nxt_s;
      lap_act_r  <= lap_act_nxt_s;
      running_r  <= (state_nxt_s == ST_RUN);
      rollover_r <= roll_nxt_s;
      cs_out     <= disp_cs_s;
      sec_out    <= disp_sec_s;
      min_out    <= disp_min_s;
    end
  end

endmodule
